i2c_cfg_sequencer: RTL

Upstream command sequencer for the I2C master controller: walks a register-configuration table held in an external synchronous ROM/RAM, presents one transaction at a time to the master, pulses its start strobe and waits for its end strobe. It handles NACK retry, a transfer watchdog, an inter-transaction gap, and read-back compare. Typical use is power-up configuration of sensors/PHYs. One instance drives one I2C master.

---
 rtl/i2c_cfg_pkg.sv | 49 ++++
 rtl/i2c_cfg_timer.sv | 37 +++
 rtl/i2c_cfg_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration sequencer.
// Holds the sequencer state encoding and the table-entry layout helpers.
// Entry layout, MSB to LSB:
//   last | write_flag | valid_a_bytes[1:0] | valid_d_bytes[1:0] | device_id[6:0] | reg_addr | data
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam int HDR_W = 13;  // last + write_flag + 2 + 2 + 7
  localparam int VB_W  = 2;
  localparam int DEV_W = 7;

  function automatic int entry_w(input int a_bytes, input int d_bytes);
    return HDR_W + 8 * (a_bytes + d_bytes);
  endfunction

  function automatic int off_reg(input int d_bytes);
    return 8 * d_bytes;
  endfunction

  function automatic int off_dev(input int a_bytes, input int d_bytes);
    return 8 * (a_bytes + d_bytes);
  endfunction

  function automatic int off_vd(input int a_bytes, input int d_bytes);
    return off_dev(a_bytes, d_bytes) + DEV_W;
  endfunction

  function automatic int off_va(input int a_bytes, input int d_bytes);
    return off_vd(a_bytes, d_bytes) + VB_W;
  endfunction

  function automatic int off_wr(input int a_bytes, input int d_bytes);
    return off_va(a_bytes, d_bytes) + VB_W;
  endfunction

  function automatic int off_last(input int a_bytes, input int d_bytes);
    return off_wr(a_bytes, d_bytes) + 1;
  endfunction

endpackage

// File: rtl/i2c_cfg_timer.sv
// Loadable down-counter with a zero flag; saturates at zero, never wraps.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   load_i          load load_val_i (has priority over en_i)
//   load_val_i      value to load
//   en_i            decrement by one while non-zero
//   zero_o          counter is zero
module i2c_cfg_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a register-configuration table in an external synchronous memory and
// hands one transaction at a time to an I2C master, with NACK retry, a
// transfer watchdog, an inter-transaction gap and read-back compare.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i                begin a sequence (only honoured in IDLE)
//   busy_o, done_o         sequence in progress / one-cycle end pulse
//   fail_o, mismatch_o     sticky error flags, cleared by an accepted start
//   err_index_o            index of the first failing or mismatching entry
//   tbl_addr_o, tbl_data_i table read port (1-cycle read latency)
//   i2c_*_o / *_i          transaction fields, start strobe and completion from the master
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | table address presented
// LOAD    | table word registered onto master ports
// ISSUE   | one-cycle i2c_en, watchdog armed
// WAIT    | waiting for end strobe or watchdog expiry
// GAP     | inter-transaction idle, then ISSUE (retry) or FETCH (next entry)
// DONE    | one-cycle done pulse
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int MAX_A_BYTE     = 2,
  parameter int MAX_D_BYTE     = 2,
  parameter int TBL_AW         = 6,
  parameter int ENTRY_W        = entry_w(MAX_A_BYTE, MAX_D_BYTE),
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 2 ** 20
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic                    mismatch_o,
  output logic [TBL_AW-1:0]       err_index_o,
  output logic [TBL_AW-1:0]       tbl_addr_o,
  input  logic [ENTRY_W-1:0]      tbl_data_i,
  output logic                    i2c_en_o,
  output logic                    write_flag_o,
  output logic [1:0]              valid_a_bytes_o,
  output logic [1:0]              valid_d_bytes_o,
  output logic [6:0]              device_id_o,
  output logic [8*MAX_A_BYTE-1:0] i2c_reg_addr_o,
  output logic [8*MAX_D_BYTE-1:0] i2c_tx_data_o,
  input  logic [8*MAX_D_BYTE-1:0] i2c_rx_data_i,
  input  logic                    i2c_transfer_end_i,
  input  logic                    err_flag_i
);

  localparam int A_W      = 8 * MAX_A_BYTE;
  localparam int D_W      = 8 * MAX_D_BYTE;
  localparam int OFF_REG  = off_reg(MAX_D_BYTE);
  localparam int OFF_DEV  = off_dev(MAX_A_BYTE, MAX_D_BYTE);
  localparam int OFF_VD   = off_vd(MAX_A_BYTE, MAX_D_BYTE);
  localparam int OFF_VA   = off_va(MAX_A_BYTE, MAX_D_BYTE);
  localparam int OFF_WR   = off_wr(MAX_A_BYTE, MAX_D_BYTE);
  localparam int OFF_LAST = off_last(MAX_A_BYTE, MAX_D_BYTE);
  localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              fail_q, fail_d;
  logic              mismatch_q, mismatch_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;
  logic              gap_retry_q, gap_retry_d;  // GAP exit target: ISSUE when set, FETCH otherwise

  logic              last_q, wr_q;
  logic [1:0]        va_q, vd_q;
  logic [6:0]        dev_q;
  logic [A_W-1:0]    reg_q;
  logic [D_W-1:0]    data_q;

  logic              gap_load, gap_zero, wd_load, wd_zero;
  logic [D_W-1:0]    rd_mask;
  logic              rd_miss, any_err;

  i2c_cfg_timer #(.W(GAP_W)) u_gap_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(GAP_CYCLES)),
    .en_i       (state_q == S_GAP),
    .zero_o     (gap_zero)
  );

  i2c_cfg_timer #(.W(WD_W)) u_wd_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (wd_load),
    .load_val_i (WD_W'(TIMEOUT_CYCLES)),
    .en_i       (state_q == S_WAIT),
    .zero_o     (wd_zero)
  );

  // Only the low valid_d_bytes bytes of the read-back take part in the compare.
  always_comb begin
    rd_mask = '0;
    for (int b = 0; b < MAX_D_BYTE; b++) begin
      if (b < int'(vd_q)) rd_mask[8*b +: 8] = 8'hFF;
    end
  end

  assign rd_miss = |((i2c_rx_data_i ^ data_q) & rd_mask);
  assign any_err = fail_q | mismatch_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    fail_d      = fail_q;
    mismatch_d  = mismatch_q;
    err_idx_d   = err_idx_q;
    gap_retry_d = gap_retry_q;
    gap_load    = 1'b0;
    wd_load     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d      = '0;
          retry_d    = '0;
          fail_d     = 1'b0;
          mismatch_d = 1'b0;
          err_idx_d  = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        wd_load = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An end strobe in the same cycle the watchdog expires still counts.
        if (i2c_transfer_end_i) begin
          if (err_flag_i) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d     = retry_q + RW'(1);
              gap_retry_d = 1'b1;
              gap_load    = 1'b1;
              state_d     = S_GAP;
            end else begin
              fail_d = 1'b1;
              if (!any_err) err_idx_d = idx_q;
              state_d = S_DONE;
            end
          end else begin
            if (!wr_q && rd_miss) begin
              mismatch_d = 1'b1;
              if (!any_err) err_idx_d = idx_q;
            end
            if (last_q || (idx_q == '1)) begin
              state_d = S_DONE;
            end else begin
              idx_d       = idx_q + TBL_AW'(1);
              retry_d     = '0;
              gap_retry_d = 1'b0;
              gap_load    = 1'b1;
              state_d     = S_GAP;
            end
          end
        end else if (wd_zero) begin
          fail_d = 1'b1;
          if (!any_err) err_idx_d = idx_q;
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_zero) state_d = gap_retry_q ? S_ISSUE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      err_idx_q   <= '0;
      gap_retry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      mismatch_q  <= mismatch_d;
      err_idx_q   <= err_idx_d;
      gap_retry_q <= gap_retry_d;
    end
  end

  // Master-facing fields hold from LOAD until the next LOAD, across retries.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
      wr_q   <= 1'b0;
      va_q   <= '0;
      vd_q   <= '0;
      dev_q  <= '0;
      reg_q  <= '0;
      data_q <= '0;
    end else if (state_q == S_LOAD) begin
      last_q <= tbl_data_i[OFF_LAST];
      wr_q   <= tbl_data_i[OFF_WR];
      va_q   <= tbl_data_i[OFF_VA +: 2];
      vd_q   <= tbl_data_i[OFF_VD +: 2];
      dev_q  <= tbl_data_i[OFF_DEV +: 7];
      reg_q  <= tbl_data_i[OFF_REG +: A_W];
      data_q <= tbl_data_i[0 +: D_W];
    end
  end

  assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o          = (state_q == S_DONE);
  assign fail_o          = fail_q;
  assign mismatch_o      = mismatch_q;
  assign err_index_o     = err_idx_q;
  assign tbl_addr_o      = idx_q;
  assign i2c_en_o        = (state_q == S_ISSUE);
  assign write_flag_o    = wr_q;
  assign valid_a_bytes_o = va_q;
  assign valid_d_bytes_o = vd_q;
  assign device_id_o     = dev_q;
  assign i2c_reg_addr_o  = reg_q;
  assign i2c_tx_data_o   = data_q;

endmodule
